// File: rtl/stripes_bit_serializer.sv
// stripes_bit_serializer
// Transmit side of the PE_stripes bit-serial link. Whole activation vectors are
// accepted over valid/ready into an active/shadow pair of entries and streamed
// MSB first, one bit of every lane per beat, at a per-vector precision p.
// B and the initial sum of the active entry are held for the whole burst.
`timescale 1ns/1ps

module stripes_bit_serializer #(
   parameter  int N         = 4,
   parameter  int W         = 16,
   parameter  int MP        = 16,
   localparam int OUT_WIDTH = W + $clog2(N) + MP,
   localparam int PW        = $clog2(MP + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [N*MP-1:0]      i_vec_a,
   input  logic [N*W-1:0]       i_vec_b,
   input  logic [OUT_WIDTH-1:0] i_initial_sum,
   input  logic [PW-1:0]        i_prec,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic                 o_is_msb,
   output logic                 o_is_lsb,
   output logic [N-1:0]         o_vec_a_bits,
   output logic [N*W-1:0]       o_vec_b,
   output logic [OUT_WIDTH-1:0] o_initial_sum,
   output logic                 o_busy
);

   localparam int JW = (MP > 1) ? $clog2(MP) : 1;

   typedef enum logic {IDLE, STREAM} state_t;

   typedef struct packed {
      logic [N*MP-1:0]      a;
      logic [N*W-1:0]       b;
      logic [OUT_WIDTH-1:0] sum;
      logic [PW-1:0]        prec;   // normalised to 1..MP
   } entry_t;

   state_t        state, state_n;
   entry_t        act, shd, in_entry;
   logic          shd_full;
   logic [JW-1:0] j;

   logic accept, beat_fire, last_beat;
   logic load_from_in, load_from_shd, shd_load, shd_clear;

   assign o_ready   = !shd_full;
   assign accept    = i_valid && o_ready;
   assign beat_fire = (state == STREAM) && i_ready;
   assign last_beat = beat_fire && (j == '0);

   // Build the incoming entry; precision 0 (or anything above MP) means full MP bits.
   always_comb begin
      in_entry.a    = i_vec_a;
      in_entry.b    = i_vec_b;
      in_entry.sum  = i_initial_sum;
      in_entry.prec = i_prec;
      if (i_prec == '0 || i_prec > PW'(MP)) begin
         in_entry.prec = PW'(MP);
      end
   end

   // Next-state decode: decide which entry (if any) becomes active and whether the shadow fills.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_n       = state;
      load_from_in  = 1'b0;
      load_from_shd = 1'b0;
      shd_load      = 1'b0;
      shd_clear     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               load_from_in = 1'b1;
               state_n      = STREAM;
            end
         end
         STREAM: begin
            if (last_beat) begin
               if (shd_full) begin
                  load_from_shd = 1'b1;
                  shd_clear     = 1'b1;
               end else if (accept) begin
                  load_from_in = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else if (accept) begin
               shd_load = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Active/shadow entries and the beat counter.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the entry payloads are reset as well; a reset mid-burst must discard both entries outright.
      if (rst) begin
         act      <= '0;
         shd      <= '0;
         shd_full <= 1'b0;
         j        <= '0;
      end else begin
         if (load_from_in) begin
            act <= in_entry;
            j   <= JW'(in_entry.prec - 1'b1);
         end else if (load_from_shd) begin
            act <= shd;
            j   <= JW'(shd.prec - 1'b1);
         end else if (beat_fire) begin
            j <= j - 1'b1;
         end

         if (shd_load) begin
            shd      <= in_entry;
            shd_full <= 1'b1;
         end else if (shd_clear) begin
            shd_full <= 1'b0;
         end
      end
   end

   // Beat outputs: driven from the active entry while streaming, all zero when idle.
   always_comb begin
      logic [MP-1:0] lane_a;
      o_valid       = 1'b0;
      o_busy        = 1'b0;
      o_is_msb      = 1'b0;
      o_is_lsb      = 1'b0;
      o_vec_a_bits  = '0;
      o_vec_b       = '0;
      o_initial_sum = '0;
      lane_a        = '0;
      if (state == STREAM) begin
         o_valid       = 1'b1;
         o_busy        = 1'b1;
         o_is_msb      = (j == JW'(act.prec - 1'b1));
         o_is_lsb      = (j == '0);
         o_vec_b       = act.b;
         o_initial_sum = act.sum;
         for (int i = 0; i < N; i++) begin
            lane_a          = act.a[i*MP +: MP];
            o_vec_a_bits[i] = lane_a[j];
         end
      end
   end

endmodule
